// File: rtl/apb_node_pkg.sv
// apb_node_pkg: shared types and helpers for the APB 1-to-N node.
// Holds the FSM state enum and the timeout counter width helper.
package apb_node_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    // Width of a counter that must hold 0..t; never narrower than 1 bit.
    function automatic int cnt_width(input int t);
        int w;
        w = $clog2(t + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: combinational priority address decoder.
// Ports: addr, start_addr/end_addr (inclusive ranges) -> hit, idx (lowest match).
module apb_addr_decoder
    import apb_node_pkg::*;
#(
    parameter int NB = 8,
    parameter int AW = 32,
    parameter int IW = 3
) (
    input  logic [AW-1:0]         addr,
    input  logic [NB-1:0][AW-1:0] start_addr,
    input  logic [NB-1:0][AW-1:0] end_addr,
    output logic                  hit,
    output logic [IW-1:0]         idx
);

    // Scan from the top so the lowest matching index is written last.
    // A range with start > end can never satisfy both bounds.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (addr >= start_addr[i] && addr <= end_addr[i]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/apb_node_sync.sv
// apb_node_sync: registered APB 1-to-N node with decode error and timeout.
// Ports: upstream APB slave (psel_i..pslverr_o), NB_MASTER downstream APB
// masters (psel_o..pslverr_i), per-master inclusive ranges START/END_ADDR_i.
module apb_node_sync
    import apb_node_pkg::*;
#(
    parameter int NB_MASTER      = 8,
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     psel_i,
    input  logic                                     penable_i,
    input  logic                                     pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0]                paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]                pwdata_i,
    output logic [APB_DATA_WIDTH-1:0]                prdata_o,
    output logic                                     pready_o,
    output logic                                     pslverr_o,
    output logic [NB_MASTER-1:0]                     psel_o,
    output logic [NB_MASTER-1:0]                     penable_o,
    output logic [NB_MASTER-1:0]                     pwrite_o,
    output logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] pwdata_o,
    input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] prdata_i,
    input  logic [NB_MASTER-1:0]                     pready_i,
    input  logic [NB_MASTER-1:0]                     pslverr_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] START_ADDR_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] END_ADDR_i
);

    localparam int IW = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
    localparam int CW = cnt_width(TIMEOUT_CYCLES);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                      write_q, write_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic [CW-1:0]             cnt_q, cnt_d;

    logic                      dec_hit;
    logic [IW-1:0]             dec_idx;
    logic                      active;

    apb_addr_decoder #(
        .NB (NB_MASTER),
        .AW (APB_ADDR_WIDTH),
        .IW (IW)
    ) u_dec (
        .addr       (paddr_i),
        .start_addr (START_ADDR_i),
        .end_addr   (END_ADDR_i),
        .hit        (dec_hit),
        .idx        (dec_idx)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                // Ranges are only looked at here, so an in-flight
                // transfer is immune to later range changes.
                if (psel_i && !penable_i) begin
                    addr_d  = paddr_i;
                    wdata_d = pwdata_i;
                    write_d = pwrite_i;
                    idx_d   = dec_idx;
                    rdata_d = '0;
                    err_d   = !dec_hit;
                    cnt_d   = '0;
                    state_d = dec_hit ? SETUP : RESP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready_i[idx_q]) begin
                    rdata_d = prdata_i[idx_q];
                    err_d   = pslverr_i[idx_q];
                    state_d = RESP;
                end else if (TO_EN && cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign active = (state_q == SETUP) || (state_q == ACCESS);

    // Only the selected port carries the transfer; all others sit at 0.
    always_comb begin
        psel_o    = '0;
        penable_o = '0;
        pwrite_o  = '0;
        paddr_o   = '0;
        pwdata_o  = '0;
        for (int i = 0; i < NB_MASTER; i++) begin
            if (active && idx_q == IW'(i)) begin
                psel_o[i]    = 1'b1;
                penable_o[i] = (state_q == ACCESS);
                pwrite_o[i]  = write_q;
                paddr_o[i]   = addr_q;
                pwdata_o[i]  = wdata_q;
            end
        end
    end

    assign pready_o  = (state_q == RESP);
    assign prdata_o  = pready_o ? rdata_q : '0;
    assign pslverr_o = pready_o & err_q;

endmodule
